// File: rtl/clock_time_counter.sv
// Timekeeping core of the digital clock: edge-detects the seconds-enable level,
// keeps a 24-hour hh:mm:ss time in BCD and lets hours/minutes be set via buttons.
module clock_time_counter #(
    parameter bit BOTH_EDGES = 1'b0
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       hit,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [1:0] h_tens,
    output logic [3:0] h_ones,
    output logic [2:0] m_tens,
    output logic [3:0] m_ones,
    output logic [2:0] s_tens,
    output logic [3:0] s_ones,
    output logic [1:0] field_sel,
    output logic       sec_tick
);

    typedef enum logic [1:0] {
        RUN         = 2'b00,
        SET_HOURS   = 2'b01,
        SET_MINUTES = 2'b10
    } mode_e;

    mode_e      state_q;
    logic       hit_q;
    logic [1:0] h_tens_q, h_tens_d;
    logic [3:0] h_ones_q, h_ones_d;
    logic [2:0] m_tens_q, m_tens_d;
    logic [3:0] m_ones_q, m_ones_d;
    logic [2:0] s_tens_q, s_tens_d;
    logic [3:0] s_ones_q, s_ones_d;
    logic       sec_tick_q, sec_tick_d;

    logic tick;
    logic sec_wrap, min_wrap;
    logic sec_clr, sec_adv, min_adv, hr_adv;

    // hit_q keeps following hit in every state, so leaving a SET state never
    // sees a stale level and fabricates a tick.
    assign tick = BOTH_EDGES ? (hit ^ hit_q) : (hit & ~hit_q);

    assign sec_wrap = (s_tens_q == 3'd5) && (s_ones_q == 4'd9);
    assign min_wrap = (m_tens_q == 3'd5) && (m_ones_q == 4'd9);

    // A mode press always wins: it swallows a same-cycle tick or increment.
    assign sec_clr = (state_q == RUN) && mode_btn;
    assign sec_adv = (state_q == RUN) && !mode_btn && tick;
    assign min_adv = (sec_adv && sec_wrap) ||
                     ((state_q == SET_MINUTES) && !mode_btn && inc_btn);
    assign hr_adv  = (sec_adv && sec_wrap && min_wrap) ||
                     ((state_q == SET_HOURS) && !mode_btn && inc_btn);

    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        h_tens_d   = h_tens_q;
        h_ones_d   = h_ones_q;
        m_tens_d   = m_tens_q;
        m_ones_d   = m_ones_q;
        s_tens_d   = s_tens_q;
        s_ones_d   = s_ones_q;
        sec_tick_d = sec_adv;

        if (sec_clr) begin
            s_tens_d = 3'd0;
            s_ones_d = 4'd0;
        end else if (sec_adv) begin
            if (s_ones_q == 4'd9) begin
                s_ones_d = 4'd0;
                s_tens_d = (s_tens_q == 3'd5) ? 3'd0 : s_tens_q + 3'd1;
            end else begin
                s_ones_d = s_ones_q + 4'd1;
            end
        end

        // Minutes wrap 59 -> 00 on their own; the carry into hours is hr_adv.
        if (min_adv) begin
            if (m_ones_q == 4'd9) begin
                m_ones_d = 4'd0;
                m_tens_d = (m_tens_q == 3'd5) ? 3'd0 : m_tens_q + 3'd1;
            end else begin
                m_ones_d = m_ones_q + 4'd1;
            end
        end

        if (hr_adv) begin
            if ((h_tens_q == 2'd2) && (h_ones_q == 4'd3)) begin
                h_tens_d = 2'd0;
                h_ones_d = 4'd0;
            end else if (h_ones_q == 4'd9) begin
                h_ones_d = 4'd0;
                h_tens_d = h_tens_q + 2'd1;
            end else begin
                h_ones_d = h_ones_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            hit_q      <= 1'b0;
            h_tens_q   <= 2'd0;
            h_ones_q   <= 4'd0;
            m_tens_q   <= 3'd0;
            m_ones_q   <= 4'd0;
            s_tens_q   <= 3'd0;
            s_ones_q   <= 4'd0;
            sec_tick_q <= 1'b0;
        end else begin
            hit_q      <= hit;
            h_tens_q   <= h_tens_d;
            h_ones_q   <= h_ones_d;
            m_tens_q   <= m_tens_d;
            m_ones_q   <= m_ones_d;
            s_tens_q   <= s_tens_d;
            s_ones_q   <= s_ones_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else if (mode_btn) begin
            case (state_q)
                RUN:         state_q <= SET_HOURS;
                SET_HOURS:   state_q <= SET_MINUTES;
                SET_MINUTES: state_q <= RUN;
                default:     state_q <= RUN;
            endcase
        end
    end

    assign h_tens    = h_tens_q;
    assign h_ones    = h_ones_q;
    assign m_tens    = m_tens_q;
    assign m_ones    = m_ones_q;
    assign s_tens    = s_tens_q;
    assign s_ones    = s_ones_q;
    assign field_sel = state_q;
    assign sec_tick  = sec_tick_q;

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- Timekeeping core of the digital clock, directly downstream of the seconds-enable stage.
- Consumes the seconds-enable `hit` level, which toggles once per period, and edge-detects it into one-second ticks.
- Maintains a 24-hour hh:mm:ss time in BCD digits and drives the display/multiplexer stage.
- Small mode FSM allows hours and minutes to be set with pre-debounced single-cycle button pulses.

Parameters:
- BOTH_EDGES, 0. 0 = rising edge of `hit` is a tick. 1 = every toggle of `hit` is a tick.

Ports:
- ck  input  1  system clock; `hit` is in the same clock domain.
- reset  input  1  asynchronous, active-high.
- hit  input  1  toggling level from the seconds-enable stage.
- mode_btn  input  1  single-cycle pulse; advances the mode FSM.
- inc_btn  input  1  single-cycle pulse; increments the field being set.
- h_tens  output  2  hours tens digit, 0-2.
- h_ones  output  4  hours ones digit, 0-9.
- m_tens  output  3  minutes tens digit, 0-5.
- m_ones  output  4  minutes ones digit, 0-9.
- s_tens  output  3  seconds tens digit, 0-5.
- s_ones  output  4  seconds ones digit, 0-9.
- field_sel  output  2  00 = RUN, 01 = SET_HOURS, 10 = SET_MINUTES; used for display blinking.
- sec_tick  output  1  registered one-cycle pulse, high in the cycle the seconds advance.

Behaviour:
- Reset (async): all digits 0 (00:00:00), state RUN, field_sel 00, sec_tick 0, hit_d 0.
- Edge detect: hit_d registers `hit` every cycle.
  - tick = hit & ~hit_d when BOTH_EDGES = 0.
  - tick = hit ^ hit_d when BOTH_EDGES = 1.
  - tick is combinational.
- Latency: `hit` rises at clock edge N → digits update and sec_tick = 1 at edge N+1 → sec_tick = 0 at edge N+2.
- RUN counting on tick:
  - s_ones 9 → 0 with carry to s_tens.
  - s_tens 5 and s_ones 9 → seconds 00, carry to minutes.
  - Minutes follow the same rule, carrying to hours.
  - Hours: h_ones 9 → 0 with carry to h_tens.
  - 23:59:59 → 00:00:00 (h_tens 2, h_ones 3 wraps to 00).
- FSM states and transitions on mode_btn: RUN → SET_HOURS → SET_MINUTES → RUN. field_sel reflects the state.
- Entering SET_HOURS: seconds cleared to 00 on the same edge. Seconds stay frozen at 00 in both SET states.
- In SET states: ticks ignored, sec_tick stays 0. hit_d keeps tracking `hit`, so returning to RUN produces no spurious tick.
- inc_btn in SET_HOURS: hours +1, 23 → 00. Minutes unaffected.
- inc_btn in SET_MINUTES: minutes +1, 59 → 00. No carry into hours.
- inc_btn in RUN: ignored.
- Priority:
  - mode_btn and inc_btn in the same cycle: mode transition taken, inc ignored.
  - tick and mode_btn in the same cycle in RUN: transition taken, tick discarded, seconds cleared, sec_tick = 0.
- Returning to RUN: counting resumes from the set time at :00 on the next tick.
- Invariant: digits never leave their legal ranges.
- Reset mid-operation: immediately returns to the reset values regardless of state or pending pulses.

Test Plan:
- Reset, then toggle `hit` 0→1 (BOTH_EDGES = 0) → one cycle later sec_tick = 1 and time = 00:00:01. The following 1→0 toggle produces no tick.
- From 00:00:59, one tick → 00:01:00. From 23:59:59, one tick → 00:00:00 with a single sec_tick.
- With time at 12:34:56: mode_btn → field_sel = 01, seconds 00. inc_btn ×12 → hours 00, minutes 34. mode_btn → field_sel = 10. inc_btn ×26 → 00:00:00. mode_btn → RUN.
- In SET_MINUTES, toggle `hit` repeatedly → no sec_tick, time unchanged. Return to RUN with hit = 1 steady → no tick until the next rising edge.
- Simultaneous mode_btn + inc_btn in SET_HOURS → moves to SET_MINUTES, hours unchanged. Simultaneous tick + mode_btn in RUN → SET_HOURS, seconds 00, sec_tick = 0.
- BOTH_EDGES = 1: toggle `hit` 4 times from reset → 00:00:04. Assert reset mid-sequence → all outputs 0 immediately, asynchronously, without waiting for a clock edge.
